mul_issue_ctrl: RTL and testbench
=================================

# mul_issue_ctrl

Sequencing controller for the 32x32 integer multiplier in the execute stage. Accepts RISC-V M-extension multiply ops (MUL/MULH/MULHSU/MULHU) over a valid/ready handshake. Drives the unsigned `Multiplier32_wallace` core with operand magnitudes and applies sign correction and half selection over registered stages. Keeps a one-entry last-product cache so that a MULH/MUL pair on identical operands completes the second op in one cycle.

## Interface
- `BYPASS_EN`, default 1: 1 enables the last-product cache; 0 forces every op down the full path.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous kill of the in-flight op.
- `in_valid` in 1: request valid.
- `in_ready` out 1: controller can accept a request.
- `in_op` in 2: encodings are 00 MUL (low word, signed×signed), 01 MULH (high, s×s), 10 MULHSU (high, s×u), 11 MULHU (high, u×u).
- `in_a` in 32: rs1 operand.
- `in_b` in 32: rs2 operand.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_result` out 32: selected product word.
- `out_hit` out 1: the current result came from the cache; valid only with `out_valid`.

## Operation
- States: IDLE, MUL, FIX, DONE.
- `in_ready` = (state==IDLE) & !rst. The accept event is `in_valid & in_ready`.
- Mode is derived from `in_op`:
  - `a_s` = (op != 11).
  - `b_s` = (op == 00 | op == 01).
- Result sign: `neg` = (`a_s` & a[31]) ^ (`b_s` & b[31]).
- Operand magnitudes: |a| = (`a_s` & a[31]) ? -a : a, and likewise for b. 0x80000000 maps to 0x80000000 as an unsigned magnitude.
- IDLE, on accept:
  - Latch op, `neg`, |a| and |b|.
  - Cache hit when `BYPASS_EN` & `cache_valid` & a==`key_a` & b==`key_b` & {`a_s`,`b_s`}==`key_mode`.
  - On a hit: go to DONE, load `out_result` from the cached 64-bit product (low word for op 00, high word otherwise), set `out_hit`=1.
  - On a miss: go to MUL, `out_hit`=0.
- MUL: register the 64-bit unsigned core output into `prod_u`, then go to FIX.
- FIX:
  - Compute `prod_s` = `neg` ? -`prod_u` : `prod_u` (64-bit two's complement).
  - Load `out_result` with the selected word.
  - Write the cache: `key_a`, `key_b`, `key_mode`, `prod_s`; set `cache_valid`=1.
  - Go to DONE.
- DONE: `out_valid`=1. On `out_ready`, go to IDLE. `out_result` and `out_hit` stay stable while stalled.
- Flush:
  - `flush` high in MUL, FIX or DONE: next state is IDLE and `out_valid` drops next cycle.
  - A flush in MUL or FIX does not write the cache.
  - A flush in IDLE is a no-op; an accept in the same cycle is dropped. `in_ready` is still 1, so the requester must treat that op as killed.
- MUL low word does not depend on signedness, but the cache key still includes the mode. MUL and MULH share mode s×s, so the fused pair hits.
- All products are exact modulo 2^64; there is no overflow signalling.

## Timing
- Reset values:
  - State IDLE.
  - `out_valid`=0, `out_result`=0, `out_hit`=0.
  - `cache_valid`=0; `key_*` and `prod_*` are 0.
  - `in_ready` is 0 while `rst` is high and 1 in the first cycle after.
- Miss latency: accept at cycle N, `out_valid` at N+3.
- Hit latency: accept at cycle N, `out_valid` at N+1.
- At most one op is in flight.
- `out_valid` & `out_ready` at cycle M gives `in_ready` at M+1, so back-to-back throughput is 1 op per 4 cycles on misses and 1 per 2 on hits.
- `rst` overrides `flush` and handshakes in the same cycle. `rst` in any state returns to reset values next cycle, including `cache_valid`=0.
- `flush` overrides `out_ready` in DONE. The result is discarded and no handshake is counted.
- `BYPASS_EN`=0: `cache_valid` is still written but never hits, and `out_hit` is always 0.

## Test plan
- MULH a=0xFFFFFFF9 (-7), b=0x00000003: `out_result`=0xFFFFFFFF, `out_hit`=0, 3 cycles. Then MUL with the same operands: `out_result`=0xFFFFFFEB, `out_hit`=1, 1 cycle.
- MULHU a=b=0xFFFFFFFF gives 0xFFFFFFFE. MULHSU a=0x80000000, b=0xFFFFFFFF gives 0x80000000. MULH a=b=0x80000000 gives 0x40000000. Each is a miss at 3 cycles.
- Backpressure: MUL 0x0001_0000 × 0x0001_0000 with `out_ready` low for 5 cycles. `out_valid` and `out_result`=0x00000000 are held; `in_ready`=0 throughout. Accept completes on the first cycle `out_ready`=1.
- Flush: assert `flush` the cycle after accepting MULHU 5×7. No `out_valid`; `in_ready`=1 the next cycle. An immediate MULHU 5×7 is a miss (`out_hit`=0) with `out_result`=0.
- Reset mid-op: `rst` in FIX. The next cycle has `out_valid`=0 and `out_result`=0. A previously cached operand pair now misses.
- `BYPASS_EN`=0: repeat the first scenario. Both ops take 3 cycles, `out_hit`=0, and the results are unchanged.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// Sequencing controller for the 32x32 multiplier: magnitude/sign split, registered
// sign fix-up and half select, plus a one-entry last-product cache for fused pairs.

module Multiplier32_wallace (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] p
);
   assign p = {32'b0, a} * {32'b0, b};
endmodule

module mul_issue_ctrl #(
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_hit
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]  state;
   logic [1:0]  op_q;
   logic        neg_q;
   logic [31:0] mag_a_q, mag_b_q;
   logic [31:0] a_q, b_q;
   logic [1:0]  mode_q;
   logic [63:0] prod_u;

   logic        cache_valid;
   logic [31:0] key_a, key_b;
   logic [1:0]  key_mode;
   logic [63:0] cache_prod;

   logic        a_s, b_s, neg, hit;
   logic [31:0] mag_a, mag_b;
   logic [63:0] core_p, prod_s;

   assign in_ready  = (state == IDLE) & ~rst;
   assign out_valid = (state == DONE);

   assign a_s   = (in_op != 2'b11);
   assign b_s   = ~in_op[1];
   assign neg   = (a_s & in_a[31]) ^ (b_s & in_b[31]);
   assign mag_a = (a_s & in_a[31]) ? -in_a : in_a;
   assign mag_b = (b_s & in_b[31]) ? -in_b : in_b;
   assign hit   = BYPASS_EN & cache_valid & (in_a == key_a) & (in_b == key_b)
                & ({a_s, b_s} == key_mode);

   assign prod_s = neg_q ? -prod_u : prod_u;

   Multiplier32_wallace u_core (
      .a (mag_a_q),
      .b (mag_b_q),
      .p (core_p)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         op_q        <= '0;
         neg_q       <= 1'b0;
         mag_a_q     <= '0;
         mag_b_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         mode_q      <= '0;
         prod_u      <= '0;
         cache_valid <= 1'b0;
         key_a       <= '0;
         key_b       <= '0;
         key_mode    <= '0;
         cache_prod  <= '0;
         out_result  <= '0;
         out_hit     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // a flush coinciding with an accept kills the op before it starts
               if (in_valid && !flush) begin
                  op_q    <= in_op;
                  neg_q   <= neg;
                  mag_a_q <= mag_a;
                  mag_b_q <= mag_b;
                  a_q     <= in_a;
                  b_q     <= in_b;
                  mode_q  <= {a_s, b_s};
                  if (hit) begin
                     state      <= DONE;
                     out_result <= (in_op == 2'b00) ? cache_prod[31:0] : cache_prod[63:32];
                     out_hit    <= 1'b1;
                  end else begin
                     state   <= MUL;
                     out_hit <= 1'b0;
                  end
               end
            end
            MUL: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  prod_u <= core_p;
                  state  <= FIX;
               end
            end
            FIX: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  out_result  <= (op_q == 2'b00) ? prod_s[31:0] : prod_s[63:32];
                  key_a       <= a_q;
                  key_b       <= b_q;
                  key_mode    <= mode_q;
                  cache_prod  <= prod_s;
                  cache_valid <= 1'b1;
                  state       <= DONE;
               end
            end
            default: begin
               if (flush || out_ready) state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl: scoreboard of expected results/latencies,
// covering cache hits, backpressure, flush, reset mid-op and cache disabled.

module tb_mul_issue_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, in_valid, out_ready, sel;
   logic [1:0]  in_op;
   logic [31:0] in_a, in_b;

   logic        in_ready0, out_valid0, out_hit0;
   logic        in_ready1, out_valid1, out_hit1;
   logic [31:0] out_result0, out_result1;
   logic        in_valid0, in_valid1;

   logic        rdy, ov, hitv;
   logic [31:0] res;

   assign in_valid0 = in_valid & ~sel;
   assign in_valid1 = in_valid & sel;
   assign rdy  = sel ? in_ready1   : in_ready0;
   assign ov   = sel ? out_valid1  : out_valid0;
   assign hitv = sel ? out_hit1    : out_hit0;
   assign res  = sel ? out_result1 : out_result0;

   mul_issue_ctrl #(.BYPASS_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid0), .in_ready(in_ready0),
      .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid0), .out_ready(out_ready),
      .out_result(out_result0), .out_hit(out_hit0)
   );

   mul_issue_ctrl #(.BYPASS_EN(1'b0)) u_dut_nb (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid1), .out_ready(out_ready),
      .out_result(out_result1), .out_hit(out_hit1)
   );

   typedef struct {
      logic [31:0] res;
      logic        hit;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_exp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      @(negedge clk);
      while (!rdy && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", {63'b0, rdy}, 64'd1);
      in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      @(negedge clk);
      while (!ov && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk("out_valid_wait", {63'b0, ov}, 64'd1);
   endtask

   task automatic expect_out(input string tag);
      exp_t e;
      int   lat;
      wait_out(lat);
      e = sb.pop_front();
      last_exp = e.res;
      chk({tag, "_res"}, {32'b0, res}, {32'b0, e.res});
      chk({tag, "_hit"}, {63'b0, hitv}, {63'b0, e.hit});
      chk({tag, "_lat"}, lat, e.lat);
   endtask

   task automatic retire(input string tag, input int stall);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({tag, "_stall_ov"}, {63'b0, ov}, 64'd1);
         chk({tag, "_stall_res"}, {32'b0, res}, {32'b0, last_exp});
         chk({tag, "_stall_rdy"}, {63'b0, rdy}, 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_ret_ov"}, {63'b0, ov}, 64'd0);
      chk({tag, "_ret_rdy"}, {63'b0, rdy}, 64'd1);
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input logic h,
                         input int lat, input int stall);
      exp_t e;
      e.res = r; e.hit = h; e.lat = lat;
      sb.push_back(e);
      issue(op, a, b);
      expect_out(tag);
      retire(tag, stall);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      sel = 1'b0; rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_op = 2'b00; in_a = '0; in_b = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {63'b0, in_ready0}, 64'd0);
      chk("rst_in_ready_nb", {63'b0, in_ready1}, 64'd0);
      chk("rst_out_valid", {63'b0, out_valid0}, 64'd0);
      chk("rst_out_result", {32'b0, out_result0}, 64'd0);
      chk("rst_out_hit", {63'b0, out_hit0}, 64'd0);
      rst = 1'b0;
      #1 chk("post_rst_in_ready", {63'b0, in_ready0}, 64'd1);

      // fused MULH / MUL pair
      run_op("mulh_m7x3", 2'b01, 32'hFFFFFFF9, 32'h3, 32'hFFFFFFFF, 1'b0, 3, 0);
      run_op("mul_m7x3_hit", 2'b00, 32'hFFFFFFF9, 32'h3, 32'hFFFFFFEB, 1'b1, 1, 0);

      // corner operands
      run_op("mulhu_max", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 3, 0);
      run_op("mulhsu_min", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 3, 0);
      run_op("mulh_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 3, 0);

      // backpressure
      run_op("bp", 2'b00, 32'h00010000, 32'h00010000, 32'h0, 1'b0, 3, 5);

      // flush in MUL
      issue(2'b11, 32'd5, 32'd7);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_rdy", {63'b0, rdy}, 64'd1);
      for (int i = 0; i < 4; i++) begin
         chk("flush_no_ov", {63'b0, ov}, 64'd0);
         @(negedge clk);
      end
      run_op("post_flush", 2'b11, 32'd5, 32'd7, 32'd0, 1'b0, 3, 0);

      // flush in DONE overrides out_ready; cache already written
      issue(2'b00, 32'd12, 32'd13);
      wait_out(lat);
      chk("done_flush_lat", lat, 64'd3);
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 begin flush = 1'b0; out_ready = 1'b0; end
      @(negedge clk);
      chk("done_flush_ov", {63'b0, ov}, 64'd0);
      run_op("after_done_flush", 2'b00, 32'd12, 32'd13, 32'd156, 1'b1, 1, 0);

      // flush in IDLE drops a simultaneous accept
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; in_op = 2'b00; in_a = 32'd2; in_b = 32'd3;
      @(posedge clk);
      #1 begin flush = 1'b0; in_valid = 1'b0; end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("idle_flush_no_ov", {63'b0, ov}, 64'd0);
      end
      run_op("after_idle_flush", 2'b00, 32'd2, 32'd3, 32'd6, 1'b0, 3, 0);

      // reset in FIX clears outputs and the cache
      run_op("pre_rst", 2'b00, 32'd6, 32'd7, 32'd42, 1'b0, 3, 0);
      issue(2'b01, 32'd9, 32'd9);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_ov", {63'b0, ov}, 64'd0);
      chk("midrst_res", {32'b0, res}, 64'd0);
      chk("midrst_hit", {63'b0, hitv}, 64'd0);
      chk("midrst_rdy", {63'b0, rdy}, 64'd0);
      rst = 1'b0;
      run_op("post_rst", 2'b00, 32'd6, 32'd7, 32'd42, 1'b0, 3, 0);

      // cache disabled
      sel = 1'b1;
      run_op("nb_mulh", 2'b01, 32'hFFFFFFF9, 32'h3, 32'hFFFFFFFF, 1'b0, 3, 0);
      run_op("nb_mul", 2'b00, 32'hFFFFFFF9, 32'h3, 32'hFFFFFFEB, 1'b0, 3, 0);

      chk("sb_empty", sb.size(), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
